// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine.
// Fixed-point format: z and c are Q4.12, products are Q8.24.
package mandel_pkg;

  typedef logic signed [15:0] fix_t;
  typedef logic signed [31:0] wide_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_EMIT,
    S_ADV
  } state_t;

  localparam int    FRAC       = 12;
  localparam wide_t ESC_THRESH = 32'sh0400_0000;  // 4.0 in Q8.24

  // Full-precision Q4.12 x Q4.12 -> Q8.24 product.
  function automatic wide_t fx_mul(input fix_t a, input fix_t b);
    return wide_t'(a) * wide_t'(b);
  endfunction

endpackage

// File: rtl/mandel_step.sv
// One combinational Mandelbrot step: escape test on the current z and z^2 + c.
// The escape test looks at z before the update; the caller decides which to use.
module mandel_step
  import mandel_pkg::*;
(
  input  fix_t zr,
  input  fix_t zi,
  input  fix_t c_re,
  input  fix_t c_im,
  output fix_t zr_n,
  output fix_t zi_n,
  output logic escaped
);

  wide_t       zr2;
  wide_t       zi2;
  wide_t       zri;
  wide_t       re_sum;
  wide_t       im_sum;
  logic [32:0] mag2;

  assign zr2 = fx_mul(zr, zr);
  assign zi2 = fx_mul(zi, zi);
  assign zri = fx_mul(zr, zi);

  // Squares are non-negative; one extra bit keeps their sum from wrapping
  // even when a just-escaped z is well outside the |z|<=2 disc.
  assign mag2    = {1'b0, zr2} + {1'b0, zi2};
  assign escaped = mag2 > {1'b0, ESC_THRESH};

  // c is aligned to Q8.24 before the add, then the sum is scaled back to Q4.12.
  assign re_sum = zr2 - zi2 + (wide_t'(c_re) <<< FRAC);
  assign im_sum = (zri <<< 1) + (wide_t'(c_im) <<< FRAC);

  assign zr_n = re_sum[FRAC +: 16];
  assign zi_n = im_sum[FRAC +: 16];

endmodule

// File: rtl/mandel_iter_engine.sv
// Raster-order Mandelbrot escape-time engine; steps the external pixel Counter
// so that pix_idx always names the pixel currently being iterated.
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int   IMG_W    = 160,
  parameter int   IMG_H    = 120,
  parameter int   MAX_ITER = 255,
  parameter fix_t X_MIN    = 16'shE000,
  parameter fix_t Y_MAX    = 16'sh1000,
  parameter fix_t STEP     = 16'sh0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] pix_idx,
  output logic        cnt_rst,
  output logic        cnt_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_iter,
  output logic [14:0] out_idx,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);

  state_t        state;
  state_t        state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  fix_t          c_re;
  fix_t          c_im;
  fix_t          zr;
  fix_t          zi;
  logic [7:0]    iter;

  fix_t zr_n;
  fix_t zi_n;
  logic escaped;
  logic iter_done;
  logic last_pix;

  mandel_step u_step (
    .zr      (zr),
    .zi      (zi),
    .c_re    (c_re),
    .c_im    (c_im),
    .zr_n    (zr_n),
    .zi_n    (zi_n),
    .escaped (escaped)
  );

  assign iter_done = escaped || (iter == ITER_CAP);
  assign last_pix  = (x == X_LAST) && (y == Y_LAST);

  // Outputs decode from registered state only, so ready never feeds valid.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n    = state;
    out_valid  = 1'b0;
    cnt_en     = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (start) state_n = S_INIT;
      S_INIT: state_n = S_ITER;
      S_ITER: if (iter_done) state_n = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_ADV;
      end
      S_ADV: begin
        cnt_en     = 1'b1;
        frame_done = last_pix;
        state_n    = last_pix ? S_IDLE : S_INIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      cnt_rst  <= 1'b0;
      x        <= '0;
      y        <= '0;
      c_re     <= '0;
      c_im     <= '0;
      zr       <= '0;
      zi       <= '0;
      iter     <= '0;
      out_iter <= '0;
      out_idx  <= '0;
    end else begin
      state   <= state_n;
      cnt_rst <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt_rst <= 1'b1;
            c_re    <= X_MIN;
            c_im    <= Y_MAX;
            x       <= '0;
            y       <= '0;
          end
        end
        S_INIT: begin
          zr   <= '0;
          zi   <= '0;
          iter <= '0;
        end
        S_ITER: begin
          if (iter_done) begin
            out_iter <= iter;
            out_idx  <= pix_idx;
          end else begin
            zr   <= zr_n;
            zi   <= zi_n;
            iter <= iter + 8'd1;
          end
        end
        S_ADV: begin
          // The last pixel leaves x/y/c alone; the next start reloads them.
          if (x == X_LAST) begin
            if (y != Y_LAST) begin
              x    <= '0;
              y    <= y + YW'(1);
              c_re <= X_MIN;
              c_im <= c_im - STEP;
            end
          end else begin
            x    <= x + XW'(1);
            c_re <= c_re + STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Scoreboard bench for mandel_iter_engine on a 4x2 frame (c = -2..1, 0..-1i)
// plus a 1x1 instance at c = 2+0i for the latency and |z|^2 == 4 boundary.
`timescale 1ns/1ps
module tb_mandel_iter_engine;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int MI = 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        start     = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] pix_idx;
  logic        cnt_rst;
  logic        cnt_en;
  logic        out_valid;
  logic [7:0]  out_iter;
  logic [14:0] out_idx;
  logic        busy;
  logic        frame_done;

  logic        start2 = 1'b0;
  logic        ready2 = 1'b0;
  logic        cnt_rst2;
  logic        cnt_en2;
  logic        out_valid2;
  logic [7:0]  out_iter2;
  logic [14:0] out_idx2;
  logic        busy2;
  logic        frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_iter_q[$];
  int exp_idx_q[$];

  int n_cnt_rst      = 0;
  int n_cnt_en       = 0;
  int n_frame_done   = 0;

  always #5 clk = ~clk;

  // Pixel Counter driven only by the engine; deliberately not cleared by rst.
  logic [14:0] pix_cnt = '0;
  always @(posedge clk) begin
    if (cnt_rst)     pix_cnt <= '0;
    else if (cnt_en) pix_cnt <= pix_cnt + 15'd1;
  end
  assign pix_idx = pix_cnt;

  always @(negedge clk) begin
    if (cnt_rst)    n_cnt_rst++;
    if (cnt_en)     n_cnt_en++;
    if (frame_done) n_frame_done++;
  end

  mandel_iter_engine #(
    .IMG_W(W), .IMG_H(H), .MAX_ITER(MI),
    .X_MIN(16'shE000), .Y_MAX(16'sh0000), .STEP(16'sh1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_idx(pix_idx),
    .cnt_rst(cnt_rst), .cnt_en(cnt_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_iter(out_iter), .out_idx(out_idx),
    .busy(busy), .frame_done(frame_done)
  );

  mandel_iter_engine #(
    .IMG_W(1), .IMG_H(1), .MAX_ITER(MI),
    .X_MIN(16'sh2000), .Y_MAX(16'sh0000), .STEP(16'sh1000)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pix_idx(15'd0),
    .cnt_rst(cnt_rst2), .cnt_en(cnt_en2), .out_valid(out_valid2),
    .out_ready(ready2), .out_iter(out_iter2), .out_idx(out_idx2),
    .busy(busy2), .frame_done(frame_done2)
  );

  // Real-valued escape-time reference; exact for the integer c used here.
  function automatic int model_iter(input real cr, input real ci, input int max_iter);
    real zr = 0.0;
    real zi = 0.0;
    real t;
    for (int k = 0; k < max_iter; k++) begin
      if (zr * zr + zi * zi > 4.0) return k;
      t  = zr * zr - zi * zi + cr;
      zi = 2.0 * zr * zi + ci;
      zr = t;
    end
    return max_iter;
  endfunction

  task automatic load_frame();
    exp_iter_q.delete();
    exp_idx_q.delete();
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        exp_iter_q.push_back(model_iter(-2.0 + 1.0 * xx, 0.0 - 1.0 * yy, MI));
        exp_idx_q.push_back(yy * W + xx);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Pops the scoreboard on every accepted result until the frame ends.
  task automatic drain(input string tag, input int budget);
    bit seen_done = 1'b0;
    bit finished  = 1'b0;
    int ei;
    int ex;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_iter_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: unexpected result iter=%0d idx=%0d", tag, out_iter, out_idx);
        end else begin
          ei = exp_iter_q.pop_front();
          ex = exp_idx_q.pop_front();
          if (out_iter !== 8'(ei) || out_idx !== 15'(ex)) begin
            n_fail++;
            $display("FAIL %s_result: got iter=%0d idx=%0d, expected iter=%0d idx=%0d",
                     tag, out_iter, out_idx, ei, ex);
          end
        end
      end
      if (frame_done) seen_done = 1'b1;
      if (seen_done && !busy) finished = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s_timeout: frame not finished after %0d cycles, busy=%0b", tag, budget, busy);
    end
    n_checks++;
    if (exp_iter_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d results outstanding, expected 0", tag, exp_iter_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cnt_rst, cnt_en, out_valid, busy, frame_done, out_iter, out_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cnt_rst=%0b cnt_en=%0b valid=%0b busy=%0b done=%0b iter=%0d idx=%0d, expected all 0",
               cnt_rst, cnt_en, out_valid, busy, frame_done, out_iter, out_idx);
    end
    n_checks++;
    if ({busy2, out_valid2, out_iter2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: busy=%0b valid=%0b iter=%0d, expected all 0", busy2, out_valid2, out_iter2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int r0 = n_cnt_rst;
    int e0 = n_cnt_en;
    int d0 = n_frame_done;
    load_frame();
    out_ready = 1'b1;
    pulse_start();
    n_checks++;
    if (cnt_rst !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start: cnt_rst=%0b busy=%0b, expected 1 1", cnt_rst, busy);
    end
    drain("frame", 2000);
    n_checks++;
    if (n_cnt_rst - r0 != 1) begin
      n_fail++;
      $display("FAIL frame_cnt_rst: %0d pulses, expected 1", n_cnt_rst - r0);
    end
    n_checks++;
    if (n_cnt_en - e0 != W * H) begin
      n_fail++;
      $display("FAIL frame_cnt_en: %0d pulses, expected %0d", n_cnt_en - e0, W * H);
    end
    n_checks++;
    if (n_frame_done - d0 != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: %0d pulses, expected 1", n_frame_done - d0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy_end: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_latency_boundary();
    int lat = 0;
    int wait_cyc = 0;
    ready2 = 1'b1;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    while (!out_valid2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL latency: out_valid %0d cycles after INIT, expected 4", lat);
    end
    n_checks++;
    if (out_iter2 !== 8'(model_iter(2.0, 0.0, MI)) || out_idx2 !== 15'd0) begin
      n_fail++;
      $display("FAIL boundary_c2: iter=%0d idx=%0d, expected iter=%0d idx=0",
               out_iter2, out_idx2, model_iter(2.0, 0.0, MI));
    end
    while (busy2 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_idle: busy=%0b, expected 0", busy2);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  hold_iter;
    logic [14:0] hold_idx;
    int          e0;
    int          cyc = 0;
    load_frame();
    out_ready = 1'b0;
    pulse_start();
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL bp_valid_timeout: out_valid=%0b, expected 1", out_valid);
    end
    hold_iter = out_iter;
    hold_idx  = out_idx;
    e0        = n_cnt_en;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_iter !== hold_iter || out_idx !== hold_idx || cnt_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%0b iter=%0d idx=%0d cnt_en=%0b, expected 1 %0d %0d 0",
                 out_valid, out_iter, out_idx, cnt_en, hold_iter, hold_idx);
      end
    end
    n_checks++;
    if (n_cnt_en != e0) begin
      n_fail++;
      $display("FAIL bp_cnt_en: %0d pulses during stall, expected 0", n_cnt_en - e0);
    end
    out_ready = 1'b1;
    drain("backpressure", 2000);
  endtask

  task automatic test_reset_mid_iter();
    int adv = 0;
    int r0;
    load_frame();
    out_ready = 1'b1;
    pulse_start();
    for (int cyc = 0; cyc < 300 && adv < 2; cyc++) begin
      @(negedge clk);
      if (cnt_en) adv++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || pix_idx !== 15'd2) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%0b valid=%0b pix_idx=%0d, expected 1 0 2", busy, out_valid, pix_idx);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cnt_rst, cnt_en, out_valid, busy, frame_done, out_iter, out_idx} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: cnt_rst=%0b cnt_en=%0b valid=%0b busy=%0b done=%0b iter=%0d idx=%0d, expected all 0",
               cnt_rst, cnt_en, out_valid, busy, frame_done, out_iter, out_idx);
    end
    @(negedge clk) rst = 1'b0;
    r0 = n_cnt_rst;
    pulse_start();
    n_checks++;
    if (cnt_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_cnt_rst: cnt_rst=%0b, expected 1", cnt_rst);
    end
    drain("restart", 2000);
    n_checks++;
    if (n_cnt_rst - r0 != 1) begin
      n_fail++;
      $display("FAIL restart_cnt_rst_count: %0d pulses, expected 1", n_cnt_rst - r0);
    end
  endtask

  task automatic test_start_while_busy();
    int r0 = n_cnt_rst;
    load_frame();
    out_ready = 1'b1;
    pulse_start();
    repeat (4) @(negedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    drain("busy_start", 2000);
    n_checks++;
    if (n_cnt_rst - r0 != 1) begin
      n_fail++;
      $display("FAIL busy_start_cnt_rst: %0d pulses, expected 1", n_cnt_rst - r0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_latency_boundary();
    test_backpressure();
    test_reset_mid_iter();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
